uart_tx_arbiter: RTL and testbench

//  Shares one UART_tx transmitter between NUM_REQ byte requesters. Requesters
//  are served in round-robin order. The block issues a 1-cycle tx_start with a

---
 rtl/uart_tx_arbiter_if.sv | 13 +
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART transmit arbiter: per-requester valid/data in,
// one-hot ready and frame-done pulses back.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   req_done;

    modport master (output req_valid, req_data, input req_ready, req_done);
    modport slave  (input req_valid, req_data, output req_ready, req_done);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_tx among NUM_REQ byte requesters, with
// frame-done watchdog and inter-frame gap.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | arbitrate; winner sees req_ready and its byte is latched
// START     | tx_start high for this one cycle, watchdog loaded
// WAIT_DONE | waiting for tx_done_tick, watchdog counting down
// GAP       | GAP_CYCLES idle cycles before the next arbitration
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 32
) (
    input  logic                       UART_clk,
    input  logic                       rst,
    uart_tx_arbiter_if.slave           req,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done_tick,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int GID_W    = $clog2(NUM_REQ);
    localparam int WD_W     = $clog2(TIMEOUT);
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t           state;
    logic [GID_W-1:0] last_grant;
    logic [GID_W-1:0] win_id;
    logic             win_found;
    logic [WD_W-1:0]  wd_cnt;
    logic [7:0]       gap_cnt;
    int               scan_idx;

    // Scan from the lowest priority (last_grant) up to the highest, so the
    // last hit is the requester closest after last_grant.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_idx = int'(last_grant) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (req.req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_id    = GID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        req.req_ready = '0;
        if (state == IDLE && win_found) begin
            req.req_ready[win_id] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge UART_clk) begin
        if (rst) begin
            state        <= IDLE;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            last_grant   <= GID_W'(NUM_REQ - 1);
            req.req_done <= '0;
            timeout_err  <= 1'b0;
            wd_cnt       <= '0;
            gap_cnt      <= '0;
        end else begin
            tx_start     <= 1'b0;
            req.req_done <= '0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        tx_data    <= req.req_data[8*win_id +: 8];
                        grant_id   <= win_id;
                        last_grant <= win_id;
                        tx_start   <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    wd_cnt <= WD_W'(TIMEOUT - 1);
                    state  <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A done tick on the watchdog's last cycle still counts as done.
                    if (tx_done_tick) begin
                        req.req_done[grant_id] <= 1'b1;
                        gap_cnt                <= 8'(GAP_LOAD);
                        state                  <= AFTER_FRAME;
                    end else if (wd_cnt == '0) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= 8'(GAP_LOAD);
                        state       <= AFTER_FRAME;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: arbitration table, directed corner sequences and a
// randomized run against a cycle-timed transaction model with a stubbed UART_tx.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int GAP   = 2;
    localparam int TO    = 32;
    localparam int FRAME = 11;

    logic         UART_clk = 1'b0;
    logic         rst;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_done_tick;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout_err;

    uart_tx_arbiter_if #(.NUM_REQ(N)) rif ();

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .UART_clk     (UART_clk),
        .rst          (rst),
        .req          (rif),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_tick (tx_done_tick),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 UART_clk = ~UART_clk;

    typedef struct {
        logic [N-1:0] valid;
        logic [31:0]  data;
        int           exp_gid;
    } vec_t;

    vec_t tbl[12];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // model: cycle numbers of expected events for the frame in flight
    bit         checking_on = 0;
    bit         m_accepted  = 0;
    int         m_idle_at   = 0;
    int         m_last      = N - 1;
    int         m_start     = -1;
    int         m_done      = -1;
    int         m_err       = -1;
    int         m_tick      = -1;
    int         m_wait_end  = -1;
    int         m_done_id   = 0;
    int         done_delay  = FRAME;
    logic [7:0] exp_data    = '0;
    int         exp_gid     = 0;

    logic [N-1:0] obs_ready, obs_done;
    logic         obs_start, obs_err, obs_busy;
    int           obs_gid;
    logic [7:0]   obs_data;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic cycle(input bit r, input logic [N-1:0] v, input logic [31:0] d, input bit stray);
        int           w;
        bit           idle;
        logic [N-1:0] er, ed;
        w = -1;
        @(posedge UART_clk);
        #1;
        cyc++;
        rst           = r;
        rif.req_valid = v;
        rif.req_data  = d;
        tx_done_tick  = (cyc == m_tick) ||
                        (stray && !(m_start >= 0 && cyc > m_start && cyc <= m_wait_end));
        @(negedge UART_clk);
        obs_ready = rif.req_ready;
        obs_done  = rif.req_done;
        obs_start = tx_start;
        obs_err   = timeout_err;
        obs_busy  = busy;
        obs_gid   = int'(grant_id);
        obs_data  = tx_data;
        m_accepted = 0;
        idle = (cyc >= m_idle_at);
        if (checking_on) begin
            w  = idle ? rr_pick(m_last, v) : -1;
            er = (w >= 0) ? (N'(1) << w) : '0;
            ed = (cyc == m_done) ? (N'(1) << m_done_id) : '0;
            chk("req_ready",   int'(rif.req_ready), int'(er));
            chk("req_done",    int'(rif.req_done),  int'(ed));
            chk("tx_start",    int'(tx_start),      int'(cyc == m_start));
            chk("timeout_err", int'(timeout_err),   int'(cyc == m_err));
            chk("busy",        int'(busy),          int'(!idle));
            chk("grant_id",    int'(grant_id),      exp_gid);
            chk("tx_data",     int'(tx_data),       int'(exp_data));
        end
        if (r) begin
            checking_on = 1;
            m_idle_at   = cyc + 1;
            m_last      = N - 1;
            m_start     = -1;
            m_done      = -1;
            m_err       = -1;
            m_tick      = -1;
            m_wait_end  = -1;
            exp_data    = '0;
            exp_gid     = 0;
        end else if (checking_on && w >= 0) begin
            m_accepted = 1;
            m_last     = w;
            m_done_id  = w;
            exp_gid    = w;
            exp_data   = d[8*w +: 8];
            m_start    = cyc + 1;
            if (done_delay <= TO) begin
                m_tick     = m_start + done_delay;
                m_wait_end = m_tick;
                m_done     = m_tick + 1;
                m_err      = -1;
            end else begin
                m_tick     = -1;
                m_wait_end = m_start + TO;
                m_done     = -1;
                m_err      = m_start + TO + 1;
            end
            m_idle_at = m_wait_end + 1 + GAP;
        end
    endtask

    // Present v/d until the arbiter accepts, then step into the START cycle.
    task automatic serve(input logic [N-1:0] v, input logic [31:0] d,
                         output int gid, output int dat, output int rdy, output int scyc);
        int n;
        n = 0;
        m_accepted = 0;
        while (!m_accepted && n < 300) begin
            cycle(1'b0, v, d, 1'b0);
            n++;
        end
        chk("accept_bound", int'(m_accepted), 1);
        rdy = int'(obs_ready);
        cycle(1'b0, '0, d, 1'b0);
        chk("start_latency", int'(obs_start), 1);
        gid  = obs_gid;
        dat  = int'(obs_data);
        scyc = cyc;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout @cyc %0d: got running, want finished", cyc);
        $fatal(1);
    end

    initial begin
        int gid, dat, rdy, sc, prev, n, cnt;
        int order[5];
        logic [7:0] bytes3[3];
        order  = '{0, 1, 2, 3, 0};
        bytes3 = '{8'hA7, 8'h00, 8'hFF};

        tbl[0]  = '{4'b0001, 32'h0000_0055, 0};
        tbl[1]  = '{4'b1111, 32'h0,         1};
        tbl[2]  = '{4'b1111, 32'h0,         2};
        tbl[3]  = '{4'b1111, 32'h0,         3};
        tbl[4]  = '{4'b1111, 32'h0,         0};
        tbl[5]  = '{4'b0100, 32'h0,         2};
        tbl[6]  = '{4'b0100, 32'h0,         2};
        tbl[7]  = '{4'b1001, 32'h0,         3};
        tbl[8]  = '{4'b1001, 32'h0,         0};
        tbl[9]  = '{4'b0110, 32'h0,         1};
        tbl[10] = '{4'b1000, 32'h0,         3};
        tbl[11] = '{4'b0011, 32'h0,         0};
        for (int i = 1; i < 12; i++) tbl[i].data = $urandom;

        rst           = 1'b1;
        rif.req_valid = '0;
        rif.req_data  = '0;
        tx_done_tick  = 1'b0;
        cycle(1'b1, '0, '0, 1'b0);
        cycle(1'b1, '0, '0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            serve(tbl[i].valid, tbl[i].data, gid, dat, rdy, sc);
            chk("tbl_ready", rdy, 1 << tbl[i].exp_gid);
            chk("tbl_grant", gid, tbl[i].exp_gid);
            chk("tbl_data",  dat, int'(tbl[i].data[8*tbl[i].exp_gid +: 8]));
        end

        // all four held: strict rotation, fixed frame period
        cycle(1'b1, '0, '0, 1'b0);
        cycle(1'b1, '0, '0, 1'b0);
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            serve(4'b1111, 32'h4433_2211, gid, dat, rdy, sc);
            chk("rr_order", gid, order[k]);
            chk("rr_data",  dat, 8'h11 * (order[k] + 1));
            if (prev >= 0) chk("frame_period", sc - prev, 2 + FRAME + GAP);
            prev = sc;
        end

        // lone requester 2, back-to-back
        prev = -1;
        for (int k = 0; k < 3; k++) begin
            serve(4'b0100, 32'(bytes3[k]) << 16, gid, dat, rdy, sc);
            chk("lone_grant", gid, 2);
            chk("lone_data",  dat, int'(bytes3[k]));
            if (prev >= 0) chk("lone_period", sc - prev, 2 + FRAME + GAP);
            prev = sc;
        end

        // stubbed UART: watchdog abort, then tick exactly on the last watchdog cycle
        done_delay = 1000;
        serve(4'b0001, 32'h0000_005A, gid, dat, rdy, sc);
        n = 0;
        while (!obs_err && n < 100) begin
            cycle(1'b0, '0, '0, 1'b0);
            n++;
        end
        chk("wd_latency", cyc - sc, TO + 1);
        done_delay = TO;
        serve(4'b0001, 32'h0000_005B, gid, dat, rdy, sc);
        n = 0;
        while (obs_done == '0 && n < 100) begin
            cycle(1'b0, '0, '0, 1'b0);
            n++;
        end
        chk("tick_at_limit", cyc - sc, TO + 1);
        done_delay = FRAME;

        // reset in mid-frame, then requester 0 must win
        serve(4'b0010, 32'h0000_BB00, gid, dat, rdy, sc);
        while (cyc < sc + 4) cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b1, '0, '0, 1'b0);
        cycle(1'b1, '0, '0, 1'b0);
        chk("rst_busy",   int'(obs_busy), 0);
        chk("rst_txdata", int'(obs_data), 0);
        chk("rst_grant",  obs_gid,        0);
        serve(4'b1111, 32'h4433_2211, gid, dat, rdy, sc);
        chk("post_rst_grant", gid, 0);

        // stray ticks in START, GAP and IDLE
        serve(4'b1000, 32'hC300_0000, gid, dat, rdy, sc);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            cycle(1'b0, '0, '0, 1'b1);
            if (obs_done != '0) cnt++;
        end
        chk("stray_done_count", cnt, 1);

        for (int k = 0; k < 4000; k++) begin
            case ($urandom % 8)
                6:       done_delay = $urandom_range(1, TO);
                7:       done_delay = $urandom_range(TO - 1, TO + 2);
                default: done_delay = FRAME;
            endcase
            cycle(($urandom % 400) == 0, N'($urandom), $urandom, ($urandom % 8) == 0);
        end
        done_delay = FRAME;
        for (int k = 0; k < 50; k++) cycle(1'b0, '0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
